mem_addr_seq: RTL

Parametrised successor to the instruction/data memory-address mux, for the multicycle MIPS datapath. It selects one of NUM_SRC address sources (PC, ALUOut, exception vector, and so on) and truncates the selection to the memory address width. On a start request it registers the result and issues a sequenced burst of byte addresses, so a word access runs over the byte-wide memory. It sits between the control unit and the memory address port. It adds source latching, beat sequencing, memory wait-state hold and error flagging.

---
 rtl/mem_addr_seq_if.sv | 31 +++
 rtl/mem_addr_seq.sv | 102 ++++++++++
 2 files changed

// File: rtl/mem_addr_seq_if.sv
// rtl/mem_addr_seq_if.sv - control/memory-side bundle for the memory address sequencer
// Ports (master = control unit side, slave = sequencer):
//   start, sel, word_mode, src_flat, hold : request, source select, access size, packed sources, memory wait
//   addr, addr_valid, busy, done, err     : beat address, beat live, burst active, last beat accepted, request rejected
interface mem_addr_seq_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2
);
    logic                      start;
    logic [SEL_W-1:0]          sel;
    logic                      word_mode;
    logic [NUM_SRC*DATA_W-1:0] src_flat;
    logic                      hold;
    logic [ADDR_W-1:0]         addr;
    logic                      addr_valid;
    logic                      busy;
    logic                      done;
    logic                      err;

    modport master (
        output start, sel, word_mode, src_flat, hold,
        input  addr, addr_valid, busy, done, err
    );

    modport slave (
        input  start, sel, word_mode, src_flat, hold,
        output addr, addr_valid, busy, done, err
    );
endinterface

// File: rtl/mem_addr_seq.sv
// rtl/mem_addr_seq.sv - source-select memory address mux with byte-beat burst sequencing
// Ports:
//   clk   : clock, all state on rising edge
//   reset : asynchronous active-high reset, abandons any burst
//   bus   : mem_addr_seq_if.slave (start/sel/word_mode/src_flat/hold in; addr/addr_valid/busy/done/err out)
module mem_addr_seq #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2,
    parameter int BEATS   = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_addr_seq_if.slave bus
);
    localparam int LOG_B = $clog2(BEATS);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [LOG_B-1:0]  cnt_q;
    logic [LOG_B-1:0]  last_q;
    logic              err_q;

    logic [ADDR_W-1:0] base;
    logic              sel_ok;
    logic              misaligned;
    logic              req_ok;
    logic              req_bad;
    logic              last_beat;
    logic              accept;

    // Source mux; an out-of-range select yields zero and is rejected below.
    always_comb begin
        base = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (int'(bus.sel) == i) begin
                base = bus.src_flat[i*DATA_W +: ADDR_W];
            end
        end
    end

    assign sel_ok     = int'(bus.sel) < NUM_SRC;
    // An aligned word base guarantees base+BEATS-1 never wraps the address space.
    assign misaligned = bus.word_mode && (base[LOG_B-1:0] != '0);
    assign req_ok     = (state == IDLE) && bus.start && sel_ok && !misaligned;
    assign req_bad    = (state == IDLE) && bus.start && !(sel_ok && !misaligned);
    assign last_beat  = (cnt_q == last_q);
    assign accept     = (state == ISSUE) && !bus.hold;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_ok) state_nxt = ISSUE;
            ISSUE:   if (accept && last_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: addr/err registered, the rest decoded from state; done also
    // needs hold because a held last beat has not been accepted yet.
    always_comb begin
        bus.addr       = addr_q;
        bus.addr_valid = (state == ISSUE);
        bus.busy       = (state == ISSUE);
        bus.done       = accept && last_beat;
        bus.err        = err_q;
    end

    // Address / beat datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            cnt_q  <= '0;
            last_q <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= req_bad;
            if (req_ok) begin
                addr_q <= base;
                cnt_q  <= '0;
                last_q <= bus.word_mode ? LOG_B'(BEATS - 1) : '0;
            end else if (accept && !last_beat) begin
                addr_q <= addr_q + 1'b1;
                cnt_q  <= cnt_q + 1'b1;
            end
        end
    end
endmodule
